id_issue_buffer: RTL and testbench

ID_ISSUE_BUFFER -- requirements
Module: id_issue_buffer

---
 rtl/id_issue_buffer_pkg.sv | 26 ++
 rtl/id_issue_buffer_reg_use_decode.sv | 52 +++++
 rtl/id_issue_buffer.sv | 133 +++++++++++++
 tb/tb_id_issue_buffer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_issue_buffer_pkg.sv
// Shared widths and LoongArch opcode-group constants for the decode/issue buffer.
package id_issue_buffer_pkg;

  localparam int unsigned FS_TO_DS_BUS_WD = 64;
  localparam int unsigned WS_TO_RF_BUS_WD = 38;

  localparam logic [5:0]  OP6_B          = 6'b010100;
  localparam logic [5:0]  OP6_BL         = 6'b010101;
  localparam logic [5:0]  OP6_BEQ        = 6'b010110;
  localparam logic [5:0]  OP6_BNE        = 6'b010111;
  localparam logic [5:0]  OP6_BLT        = 6'b011000;
  localparam logic [5:0]  OP6_BGE        = 6'b011001;
  localparam logic [5:0]  OP6_BLTU       = 6'b011010;
  localparam logic [5:0]  OP6_BGEU       = 6'b011011;
  localparam logic [6:0]  OP7_LU12I_W    = 7'b0001010;
  localparam logic [6:0]  OP7_PCADDU12I  = 7'b0001110;
  localparam logic [9:0]  OP10_ST_B      = 10'b0010100100;
  localparam logic [9:0]  OP10_ST_H      = 10'b0010100101;
  localparam logic [9:0]  OP10_ST_W      = 10'b0010100110;
  localparam logic [11:0] OP12_GRP_3R    = 12'h001;
  localparam logic [11:0] OP12_GRP_MDIV  = 12'h002;
  localparam logic [16:0] OP17_SLLI_W    = 17'h00081;
  localparam logic [16:0] OP17_SRLI_W    = 17'h00089;
  localparam logic [16:0] OP17_SRAI_W    = 17'h00091;

endpackage

// File: rtl/id_issue_buffer_reg_use_decode.sv
// Register-use decode: which GPRs an instruction reads and writes.
module reg_use_decode
  import id_issue_buffer_pkg::*;
(
  input  logic [31:0] inst,
  output logic        src1_valid,
  output logic [4:0]  src1,
  output logic        src2_valid,
  output logic [4:0]  src2,
  output logic        dest_valid,
  output logic [4:0]  dest
);

  logic [4:0] rd, rj, rk;
  logic       is_b, is_bl, is_cbr, is_store, is_upper, is_grp_rk, is_shift_imm;

  assign rd = inst[4:0];
  assign rj = inst[9:5];
  assign rk = inst[14:10];

  always_comb begin
    is_b         = inst[31:26] == OP6_B;
    is_bl        = inst[31:26] == OP6_BL;
    is_cbr       = (inst[31:26] == OP6_BEQ)  || (inst[31:26] == OP6_BNE)  ||
                   (inst[31:26] == OP6_BLT)  || (inst[31:26] == OP6_BGE)  ||
                   (inst[31:26] == OP6_BLTU) || (inst[31:26] == OP6_BGEU);
    is_store     = (inst[31:22] == OP10_ST_B) || (inst[31:22] == OP10_ST_H) ||
                   (inst[31:22] == OP10_ST_W);
    is_upper     = (inst[31:25] == OP7_LU12I_W) || (inst[31:25] == OP7_PCADDU12I);
    is_grp_rk    = (inst[31:20] == OP12_GRP_3R) || (inst[31:20] == OP12_GRP_MDIV);
    is_shift_imm = (inst[31:15] == OP17_SLLI_W) || (inst[31:15] == OP17_SRLI_W) ||
                   (inst[31:15] == OP17_SRAI_W);

    src1       = rj;
    src1_valid = !(is_b || is_bl || is_upper) && (rj != 5'd0);

    src2       = 5'd0;
    src2_valid = 1'b0;
    if (is_cbr || is_store) begin
      src2       = rd;
      src2_valid = rd != 5'd0;
    end else if (is_grp_rk && !is_shift_imm) begin
      src2       = rk;
      src2_valid = rk != 5'd0;
    end

    // bl links into r1; r0 is never tracked as a destination.
    dest       = is_bl ? 5'd1 : rd;
    dest_valid = !(is_b || is_cbr || is_store) && (dest != 5'd0);
  end

endmodule

// File: rtl/id_issue_buffer.sv
// Decode-stage instruction FIFO with a per-register pending-write scoreboard gating issue.
module id_issue_buffer
  import id_issue_buffer_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned BUS_WD    = FS_TO_DS_BUS_WD,
  parameter int unsigned CNT_WD    = 2,
  parameter int unsigned BYPASS_WB = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fs_to_ds_valid,
  input  logic [BUS_WD-1:0]          fs_to_ds_bus,
  output logic                       ds_allowin,
  input  logic                       es_allowin,
  output logic                       ds_to_es_valid,
  output logic [BUS_WD-1:0]          ds_to_es_bus,
  input  logic [WS_TO_RF_BUS_WD-1:0] ws_to_rf_bus,
  input  logic                       br_flush,
  output logic [31:0]                sb_busy
);

  localparam int unsigned PTR_WD = $clog2(DEPTH);
  localparam logic [PTR_WD:0] PTR_ONE = 1;
  localparam logic [CNT_WD-1:0] CNT_ONE = 1;
  localparam logic [CNT_WD-1:0] CNT_MAX = '1;

  logic [PTR_WD:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [BUS_WD-1:0] mem_q [DEPTH];
  logic [CNT_WD-1:0] cnt_q [32];
  logic [CNT_WD-1:0] cnt_d [32];

  logic full, empty, push, pop, hazard;
  logic src1_haz, src2_haz, dest_sat;
  logic [BUS_WD-1:0] head_bus;
  logic [31:0] head_inst;
  logic        src1_valid, src2_valid, dest_valid;
  logic [4:0]  src1, src2, dest;
  logic        ws_we;
  logic [4:0]  ws_waddr;
  logic        unused_wdata;

  assign ws_we        = ws_to_rf_bus[WS_TO_RF_BUS_WD-1];
  assign ws_waddr     = ws_to_rf_bus[WS_TO_RF_BUS_WD-2 -: 5];
  assign unused_wdata = ^ws_to_rf_bus[31:0];

  assign empty = rd_ptr_q == wr_ptr_q;
  assign full  = (rd_ptr_q[PTR_WD] != wr_ptr_q[PTR_WD]) &&
                 (rd_ptr_q[PTR_WD-1:0] == wr_ptr_q[PTR_WD-1:0]);

  assign ds_allowin = !full;
  assign push       = fs_to_ds_valid && ds_allowin && !br_flush;

  assign head_bus     = mem_q[rd_ptr_q[PTR_WD-1:0]];
  assign head_inst    = head_bus[BUS_WD-1 -: 32];
  assign ds_to_es_bus = head_bus;

  reg_use_decode u_reg_use_decode (
    .inst       (head_inst),
    .src1_valid (src1_valid),
    .src1       (src1),
    .src2_valid (src2_valid),
    .src2       (src2),
    .dest_valid (dest_valid),
    .dest       (dest)
  );

  // A source whose last pending write lands this cycle may issue alongside it.
  always_comb begin
    src1_haz = src1_valid && (cnt_q[src1] != '0) &&
               !((BYPASS_WB != 0) && (cnt_q[src1] == CNT_ONE) && ws_we && (ws_waddr == src1));
    src2_haz = src2_valid && (cnt_q[src2] != '0) &&
               !((BYPASS_WB != 0) && (cnt_q[src2] == CNT_ONE) && ws_we && (ws_waddr == src2));
    dest_sat = dest_valid && (cnt_q[dest] == CNT_MAX);
    hazard   = src1_haz || src2_haz || dest_sat;
  end

  assign ds_to_es_valid = !empty && !hazard && !br_flush;
  assign pop            = ds_to_es_valid && es_allowin;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (br_flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PTR_WD-1:0]] <= fs_to_ds_bus;
  end

  // Decrement at zero is ignored; a matched inc/dec pair cancels.
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      logic inc, dec;
      inc = pop && dest_valid && (dest == 5'(i));
      dec = ws_we && (ws_waddr == 5'(i)) && (i != 0) && (cnt_q[i] != '0);
      cnt_d[i] = cnt_q[i];
      if (inc && !dec)      cnt_d[i] = cnt_q[i] + CNT_ONE;
      else if (dec && !inc) cnt_d[i] = cnt_q[i] - CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '{default: '0};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    for (int i = 0; i < 32; i++) begin
      sb_busy[i] = cnt_q[i] != '0;
    end
  end

endmodule

// File: tb/tb_id_issue_buffer.sv
// Directed bench for id_issue_buffer: FIFO order/full, RAW stall, saturation, flush, reset.
module tb_id_issue_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        es_allowin;
  logic [37:0] ws_to_rf_bus;
  logic        br_flush;

  logic        allowin_a, valid_a, allowin_b, valid_b;
  logic [63:0] bus_a, bus_b;
  logic [31:0] busy_a, busy_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_issue_buffer #(.DEPTH(4), .BUS_WD(64), .CNT_WD(2), .BYPASS_WB(1)) dut (
    .clk            (clk),
    .reset          (reset),
    .fs_to_ds_valid (fs_to_ds_valid),
    .fs_to_ds_bus   (fs_to_ds_bus),
    .ds_allowin     (allowin_a),
    .es_allowin     (es_allowin),
    .ds_to_es_valid (valid_a),
    .ds_to_es_bus   (bus_a),
    .ws_to_rf_bus   (ws_to_rf_bus),
    .br_flush       (br_flush),
    .sb_busy        (busy_a)
  );

  id_issue_buffer #(.DEPTH(4), .BUS_WD(64), .CNT_WD(2), .BYPASS_WB(0)) dut_nb (
    .clk            (clk),
    .reset          (reset),
    .fs_to_ds_valid (fs_to_ds_valid),
    .fs_to_ds_bus   (fs_to_ds_bus),
    .ds_allowin     (allowin_b),
    .es_allowin     (es_allowin),
    .ds_to_es_valid (valid_b),
    .ds_to_es_bus   (bus_b),
    .ws_to_rf_bus   (ws_to_rf_bus),
    .br_flush       (br_flush),
    .sb_busy        (busy_b)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_add(input logic [4:0] rd, input logic [4:0] rj,
                                         input logic [4:0] rk);
    return {17'h00020, rk, rj, rd};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    fs_to_ds_valid = 1'b0;
    fs_to_ds_bus   = '0;
    es_allowin     = 1'b0;
    ws_to_rf_bus   = '0;
    br_flush       = 1'b0;
    #1;
    reset = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] ent;
    reset          = 1'b1;
    fs_to_ds_valid = 1'b0;
    fs_to_ds_bus   = '0;
    es_allowin     = 1'b0;
    ws_to_rf_bus   = '0;
    br_flush       = 1'b0;
    #3;
    check_eq("rst_allowin", allowin_a, 1);
    check_eq("rst_valid", valid_a, 0);
    check_eq("rst_busy", busy_a, 0);
    tick();
    reset = 1'b0;
    #1;
    check_eq("post_rst_allowin", allowin_a, 1);

    // Fill with execute stalled, then drain in order.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      fs_to_ds_valid = 1'b1;
      fs_to_ds_bus   = {mk_add(5'(10 + i), 5'd0, 5'd0), 32'h1000 + 32'(4 * i)};
      #1;
      check_eq($sformatf("fill_allowin%0d", i), allowin_a, (i < 4) ? 1 : 0);
      if (i == 0) check_eq("no_fallthrough", valid_a, 0);
      tick();
    end
    fs_to_ds_valid = 1'b0;
    #1;
    check_eq("full_allowin", allowin_a, 0);
    es_allowin = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq($sformatf("drain_valid%0d", i), valid_a, 1);
      check_eq($sformatf("drain_bus%0d", i), bus_a,
               {mk_add(5'(10 + i), 5'd0, 5'd0), 32'h1000 + 32'(4 * i)});
      tick();
    end
    #1;
    check_eq("drain_empty", valid_a, 0);
    check_eq("drain_allowin", allowin_a, 1);
    check_eq("drain_busy", busy_a, 32'h0000_3c00);

    // RAW: add.w r5,r1,r2 then add.w r6,r5,r4.
    do_reset();
    es_allowin     = 1'b1;
    fs_to_ds_valid = 1'b1;
    fs_to_ds_bus   = {mk_add(5'd5, 5'd1, 5'd2), 32'h2000};
    tick();
    fs_to_ds_bus = {mk_add(5'd6, 5'd5, 5'd4), 32'h2004};
    #1;
    check_eq("raw_i1_valid", valid_a, 1);
    check_eq("raw_i1_bus", bus_a, {mk_add(5'd5, 5'd1, 5'd2), 32'h2000});
    check_eq("raw_i1_valid_nb", valid_b, 1);
    tick();
    fs_to_ds_valid = 1'b0;
    #1;
    check_eq("raw_stall", valid_a, 0);
    check_eq("raw_stall_nb", valid_b, 0);
    check_eq("raw_busy5", busy_a[5], 1);
    tick();
    ws_to_rf_bus = {1'b1, 5'd5, 32'h0000_0055};
    #1;
    check_eq("raw_bypass", valid_a, 1);
    check_eq("raw_bypass_bus", bus_a, {mk_add(5'd6, 5'd5, 5'd4), 32'h2004});
    check_eq("raw_nobypass", valid_b, 0);
    tick();
    ws_to_rf_bus = '0;
    #1;
    check_eq("raw_after_a", valid_a, 0);
    check_eq("raw_after_nb", valid_b, 1);
    check_eq("raw_after_nb_bus", bus_b, {mk_add(5'd6, 5'd5, 5'd4), 32'h2004});
    check_eq("raw_busy_a", busy_a, 32'h0000_0040);
    tick();

    // Saturation: four r7 writers, no writeback.
    do_reset();
    es_allowin = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fs_to_ds_valid = 1'b1;
      fs_to_ds_bus   = {mk_add(5'd7, 5'd0, 5'd0), 32'h3000 + 32'(4 * i)};
      tick();
    end
    fs_to_ds_valid = 1'b0;
    #1;
    check_eq("sat_hold", valid_a, 0);
    check_eq("sat_busy", busy_a, 32'h0000_0080);
    tick();
    ws_to_rf_bus = {1'b1, 5'd7, 32'h0};
    #1;
    check_eq("sat_wb_cycle", valid_a, 0);
    tick();
    ws_to_rf_bus = '0;
    #1;
    check_eq("sat_release", valid_a, 1);
    check_eq("sat_release_bus", bus_a, {mk_add(5'd7, 5'd0, 5'd0), 32'h300c});
    tick();
    #1;
    check_eq("sat_empty", valid_a, 0);
    check_eq("sat_busy_after", busy_a, 32'h0000_0080);

    // Flush with three buffered entries and a valid input.
    do_reset();
    es_allowin     = 1'b1;
    fs_to_ds_valid = 1'b1;
    fs_to_ds_bus   = {mk_add(5'd20, 5'd0, 5'd0), 32'h4000};
    tick();
    fs_to_ds_bus = {mk_add(5'd21, 5'd0, 5'd0), 32'h4004};
    tick();
    es_allowin   = 1'b0;
    fs_to_ds_bus = {mk_add(5'd22, 5'd0, 5'd0), 32'h4008};
    tick();
    fs_to_ds_bus = {mk_add(5'd23, 5'd0, 5'd0), 32'h400c};
    tick();
    fs_to_ds_bus = {mk_add(5'd24, 5'd0, 5'd0), 32'h4010};
    br_flush     = 1'b1;
    #1;
    check_eq("flush_gate", valid_a, 0);
    tick();
    fs_to_ds_valid = 1'b0;
    br_flush       = 1'b0;
    #1;
    check_eq("flush_empty", valid_a, 0);
    check_eq("flush_allowin", allowin_a, 1);
    check_eq("flush_busy", busy_a, 32'h0010_0000);
    es_allowin     = 1'b1;
    fs_to_ds_valid = 1'b1;
    ent            = {mk_add(5'd25, 5'd0, 5'd0), 32'h4014};
    fs_to_ds_bus   = ent;
    tick();
    fs_to_ds_valid = 1'b0;
    #1;
    check_eq("flush_next_valid", valid_a, 1);
    check_eq("flush_next_bus", bus_a, ent);
    tick();

    // Issue and writeback of r9 in the same cycle.
    do_reset();
    es_allowin     = 1'b1;
    fs_to_ds_valid = 1'b1;
    fs_to_ds_bus   = {mk_add(5'd9, 5'd0, 5'd0), 32'h5000};
    tick();
    fs_to_ds_bus = {mk_add(5'd9, 5'd0, 5'd0), 32'h5004};
    tick();
    fs_to_ds_valid = 1'b0;
    ws_to_rf_bus   = {1'b1, 5'd9, 32'h0};
    #1;
    check_eq("sim_issue", valid_a, 1);
    tick();
    ws_to_rf_bus = '0;
    #1;
    check_eq("sim_cnt", busy_a, 32'h0000_0200);
    ws_to_rf_bus = {1'b1, 5'd9, 32'h0};
    tick();
    ws_to_rf_bus = '0;
    #1;
    check_eq("dec_to_zero", busy_a, 0);
    ws_to_rf_bus = {1'b1, 5'd9, 32'h0};
    tick();
    ws_to_rf_bus = '0;
    #1;
    check_eq("dec_at_zero", busy_a, 0);

    // Asynchronous reset mid-stall.
    do_reset();
    es_allowin     = 1'b1;
    fs_to_ds_valid = 1'b1;
    fs_to_ds_bus   = {mk_add(5'd11, 5'd0, 5'd0), 32'h6000};
    tick();
    fs_to_ds_bus = {mk_add(5'd12, 5'd11, 5'd0), 32'h6004};
    tick();
    fs_to_ds_bus = {mk_add(5'd13, 5'd0, 5'd0), 32'h6008};
    tick();
    fs_to_ds_valid = 1'b0;
    #1;
    check_eq("ar_stall", valid_a, 0);
    check_eq("ar_busy", busy_a, 32'h0000_0800);
    reset = 1'b1;
    #1;
    check_eq("ar_valid", valid_a, 0);
    check_eq("ar_busy0", busy_a, 0);
    check_eq("ar_allowin", allowin_a, 1);
    reset = 1'b0;
    tick();
    #1;
    check_eq("ar_empty", valid_a, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
